// File: rtl/intercal_deposit_unit.sv
// intercal_deposit_unit: multi-cycle inverse operators (UNMINGLE, DEPOSIT32,
// DEPOSIT16, PASS). A bit-serial engine handles BITS_PER_CYCLE bits per clock.
// The unit is placed behind a valid/ready handshake.
module intercal_deposit_unit #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] f
);

  localparam int unsigned DW  = 32;
  localparam int unsigned BW  = 6;   // bit base counter, 0..32
  localparam int unsigned PLW = 6;   // low/full pointer, 0..32
  localparam int unsigned PHW = 5;   // high-half pointer, 0..16

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_UNMINGLE = 2'd0;
  localparam logic [1:0] OP_DEP32    = 2'd1;
  localparam logic [1:0] OP_DEP16    = 2'd2;

  // Reject unsupported bit-engine widths at elaboration
  generate
    if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 &&
        BITS_PER_CYCLE != 4 && BITS_PER_CYCLE != 8) begin : g_bad_bpc
      $error("intercal_deposit_unit: BITS_PER_CYCLE must be 1, 2, 4 or 8");
    end
  endgenerate

  logic [1:0]     state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [DW-1:0]  a_q, a_d;
  logic [DW-1:0]  b_q, b_d;
  logic [DW-1:0]  acc_q, acc_d;
  logic [BW-1:0]  base_q, base_d;
  logic [PLW-1:0] ptr_lo_q, ptr_lo_d;
  logic [PHW-1:0] ptr_hi_q, ptr_hi_d;
  logic [DW-1:0]  f_q, f_d;
  logic           out_valid_q, out_valid_d;

  logic [DW-1:0]  acc_step;
  logic [PLW-1:0] plo_step;
  logic [PHW-1:0] phi_step;
  logic [4:0]     idx;

  // Bit engine: one RUN step over BITS_PER_CYCLE bit indices, LSB first
  always_comb begin
    acc_step = acc_q;
    plo_step = ptr_lo_q;
    phi_step = ptr_hi_q;
    idx      = '0;
    for (int j = 0; j < int'(BITS_PER_CYCLE); j++) begin
      idx = base_q[4:0] + 5'(j);
      case (op_q)
        OP_UNMINGLE: begin
          // even bits land in [15:0], odd bits in [31:16]
          acc_step[{idx[0], idx[4:1]}] = a_q[idx];
        end
        OP_DEP32: begin
          if (b_q[idx]) begin
            acc_step[idx] = a_q[plo_step[4:0]];
            plo_step      = plo_step + 6'd1;
          end
        end
        OP_DEP16: begin
          // each half consumes source bits from its own half only
          if (b_q[idx]) begin
            if (idx[4]) begin
              acc_step[idx] = a_q[{1'b1, phi_step[3:0]}];
              phi_step      = phi_step + 5'd1;
            end else begin
              acc_step[idx] = a_q[{1'b0, plo_step[3:0]}];
              plo_step      = plo_step + 6'd1;
            end
          end
        end
        default: begin
          acc_step[idx] = a_q[idx];
        end
      endcase
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    base_d      = base_q;
    ptr_lo_d    = ptr_lo_q;
    ptr_hi_d    = ptr_hi_q;
    f_d         = f_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d     = op;
          a_d      = a;
          b_d      = b;
          acc_d    = '0;
          base_d   = '0;
          ptr_lo_d = '0;
          ptr_hi_d = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // once every bit has been folded into acc, publish it
        if (base_q[BW-1]) begin
          f_d         = acc_q;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          acc_d    = acc_step;
          ptr_lo_d = plo_step;
          ptr_hi_d = phi_step;
          base_d   = base_q + BW'(BITS_PER_CYCLE);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      base_q      <= '0;
      ptr_lo_q    <= '0;
      ptr_hi_q    <= '0;
      f_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      base_q      <= base_d;
      ptr_lo_q    <= ptr_lo_d;
      ptr_hi_q    <= ptr_hi_d;
      f_q         <= f_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign f         = f_q;

endmodule

// File: tb/tb_intercal_deposit_unit.sv
// tb_intercal_deposit_unit: scoreboard bench over four instances (BPC 1,2,4,8).
module tb_intercal_deposit_unit;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] f;
  } txn_t;

  logic        clk;
  logic        rst;
  logic        in_valid  [4];
  logic        in_ready  [4];
  logic [1:0]  op        [4];
  logic [31:0] a         [4];
  logic [31:0] b         [4];
  logic        out_valid [4];
  logic        out_ready [4];
  logic [31:0] f         [4];

  txn_t sb_q[$];
  int   n_checks;
  int   n_pass;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    intercal_deposit_unit #(.BITS_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .op        (op[g]),
      .a         (a[g]),
      .b         (b[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .f         (f[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model straight from the operator definitions
  function automatic logic [31:0] ref_f(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
    logic [31:0] r;
    int k;
    r = '0;
    case (o)
      2'd0: for (int i = 0; i < 32; i++) r[(i >> 1) + ((i % 2) ? 16 : 0)] = av[i];
      2'd1: begin
        k = 0;
        for (int i = 0; i < 32; i++) if (bv[i]) begin r[i] = av[k]; k++; end
      end
      2'd2: for (int h = 0; h < 2; h++) begin
        k = 0;
        for (int i = 0; i < 16; i++) if (bv[16*h+i]) begin r[16*h+i] = av[16*h+k]; k++; end
      end
      default: r = av;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] select32(input logic [31:0] x, input logic [31:0] m);
    logic [31:0] r;
    int k;
    r = '0; k = 0;
    for (int i = 0; i < 32; i++) if (m[i]) begin r[k] = x[i]; k++; end
    return r;
  endfunction

  function automatic logic [31:0] low_mask(input int n);
    logic [63:0] one;
    one = 64'd1;
    return 32'((one << n) - 64'd1);
  endfunction

  function automatic logic [31:0] mingle(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] r;
    for (int i = 0; i < 16; i++) begin r[2*i+1] = x[i]; r[2*i] = y[i]; end
    return r;
  endfunction

  // Present one request, push its expectation once the accept edge has passed
  task automatic accept_req(input int k, input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
    txn_t t;
    int w;
    w = 0;
    while (!in_ready[k] && w < 200) begin @(posedge clk); #1; w++; end
    check_eq("in_ready_before_accept", 32'(in_ready[k]), 32'd1);
    op[k] = o; a[k] = av; b[k] = bv; in_valid[k] = 1'b1;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    op[k] = 2'($urandom_range(0, 3)); a[k] = $urandom; b[k] = $urandom;
    t.op = o; t.a = av; t.b = bv; t.f = ref_f(o, av, bv);
    sb_q.push_back(t);
  endtask

  task automatic wait_out(input int k);
    int lat;
    lat = 0;
    while (!out_valid[k] && lat < 100) begin @(posedge clk); #1; lat++; end
    check_eq("latency", 32'(lat), 32'(32 / (1 << k) + 1));
  endtask

  // Pop the expectation, compare result and its inverse property, handshake
  task automatic finish_req(input int k);
    txn_t t;
    logic [31:0] fv;
    fv = f[k];
    check_eq("sb_depth", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      t = sb_q.pop_front();
      check_eq("f_model", fv, t.f);
      case (t.op)
        2'd0: check_eq("unmingle_roundtrip", mingle(fv[31:16], fv[15:0]), t.a);
        2'd1: begin
          check_eq("dep32_select", select32(fv, t.b), t.a & low_mask($countones(t.b)));
          check_eq("dep32_unmasked_zero", fv & ~t.b, 32'd0);
        end
        2'd2: begin
          check_eq("dep16_select_lo", select32({16'd0, fv[15:0]}, {16'd0, t.b[15:0]}),
                   {16'd0, t.a[15:0]} & low_mask($countones(t.b[15:0])));
          check_eq("dep16_select_hi", select32({16'd0, fv[31:16]}, {16'd0, t.b[31:16]}),
                   {16'd0, t.a[31:16]} & low_mask($countones(t.b[31:16])));
          check_eq("dep16_unmasked_zero", fv & ~t.b, 32'd0);
        end
        default: ;
      endcase
    end
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    check_eq("out_valid_after_hs", 32'(out_valid[k]), 32'd0);
  endtask

  task automatic run_req(input int k, input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
    accept_req(k, o, av, bv);
    wait_out(k);
    finish_req(k);
  endtask

  initial begin
    logic [31:0] f_hold;
    int stray;
    logic [31:0] rb;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0; op[k] = '0; a[k] = '0; b[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      check_eq("rst_out_valid", 32'(out_valid[k]), 32'd0);
      check_eq("rst_f", f[k], 32'd0);
      check_eq("rst_in_ready", 32'(in_ready[k]), 32'd1);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed operator cases
    run_req(0, 2'd0, 32'hAAAAAAAA, 32'h0);
    check_eq("unmingle_aa", f[0], 32'hFFFF0000);
    run_req(0, 2'd0, 32'h55555555, 32'h12345678);
    check_eq("unmingle_55", f[0], 32'h0000FFFF);
    run_req(0, 2'd1, 32'h0000000F, 32'hF0F00000);
    check_eq("dep32_nibbles", f[0], 32'h00F00000);
    run_req(0, 2'd2, 32'h00030001, 32'h80018001);
    check_eq("dep16_halves", f[0], 32'h80010001);
    run_req(0, 2'd3, 32'hDEADBEEF, 32'h0);
    check_eq("pass", f[0], 32'hDEADBEEF);

    // Backpressure: result held while out_ready is low, requests ignored
    accept_req(0, 2'd1, 32'hFFFFFFFF, 32'h80000001);
    wait_out(0);
    f_hold = f[0];
    check_eq("bp_f_value", f_hold, 32'h80000001);
    for (int c = 0; c < 5; c++) begin
      in_valid[0] = 1'b1; op[0] = 2'd3; a[0] = 32'h0BADF00D;
      @(posedge clk); #1;
      check_eq("bp_out_valid", 32'(out_valid[0]), 32'd1);
      check_eq("bp_f_stable", f[0], f_hold);
      check_eq("bp_in_ready", 32'(in_ready[0]), 32'd0);
    end
    in_valid[0] = 1'b0;
    finish_req(0);
    check_eq("bp_idle_in_ready", 32'(in_ready[0]), 32'd1);
    stray = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid[0]) stray++; end
    check_eq("bp_no_stray_result", 32'(stray), 32'd0);

    // Asynchronous reset at RUN cycle 10
    accept_req(0, 2'd1, 32'h12345678, 32'hFFFF0000);
    void'(sb_q.pop_back());
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_out_valid", 32'(out_valid[0]), 32'd0);
    check_eq("arst_f", f[0], 32'd0);
    check_eq("arst_in_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    stray = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid[0]) stray++; end
    check_eq("arst_no_stray_result", 32'(stray), 32'd0);
    run_req(0, 2'd1, 32'h0000ABCD, 32'h0F0F0F0F);
    check_eq("post_rst_dep32", f[0], 32'h0A0B0C0D);

    // Random ops on every bit-engine width
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 50; n++) begin
        rb = $urandom;
        if (n % 3 == 0) rb = rb & $urandom;
        if (n == 0) rb = 32'hFFFFFFFF;
        if (n == 1) rb = 32'h0;
        run_req(k, 2'($urandom_range(0, 3)), $urandom, rb);
      end
    end

    // Unmingle round trip on random words
    for (int n = 0; n < 1000; n++) run_req(3, 2'd0, $urandom, $urandom);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
